// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counter with prescaler, one-shot/auto-reload modes
// Produces a single-cycle terminal-count pulse and registered running/done status.
module down_timer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             tc,
    output logic             done
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             tick;

    assign tick = (state_q == RUN) && (presc_q == PMAX);

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
        case (state_q)
            RUN: begin
                // A load while running only retargets the next reload; counting carries on.
                if (load) begin
                    reload_d = load_value;
                end
                if (stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (value_q > WIDTH'(1)) begin
                            value_d = value_q - WIDTH'(1);
                        end else begin
                            tc_d = 1'b1;
                            if (mode_q && (reload_q != '0)) begin
                                value_d = reload_q;
                            end else begin
                                value_d = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            default: begin
                if (load) begin
                    value_d  = load_value;
                    reload_d = load_value;
                    state_d  = IDLE;
                    presc_d  = '0;
                end else if (stop) begin
                    state_d = state_q;
                end else if (start && (state_q == IDLE) && (value_q != '0)) begin
                    state_d = RUN;
                    mode_d  = periodic;
                    presc_d = '0;
                end
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            value_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            presc_q   <= '0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            tc_q      <= tc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign value   = value_q;
    assign running = running_q;
    assign tc      = tc_q;
    assign done    = done_q;
endmodule
